// File: rtl/pet_memctl.sv
// PET memory controller: 6502 bus decode, 8096-style banked expansion RAM and a DMA port.
// Optional feature macro: PET_MEMCTL_DMA_EN enables the cycle-stealing DMA engine.
module pet_memctl #(
    parameter int unsigned EXP_BITS = 1,
    parameter int unsigned PA_W     = 16 + EXP_BITS
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            ce_cpu,
    input  logic [15:0]     cpu_addr,
    input  logic [7:0]      cpu_din,
    input  logic            cpu_we,
    output logic [7:0]      cpu_dout,
    output logic [PA_W-1:0] ram_addr,
    output logic [7:0]      ram_wdata,
    output logic            ram_we,
    input  logic [7:0]      ram_q,
    output logic [14:0]     rom_addr,
    input  logic [7:0]      rom_q,
    output logic [9:0]      vram_addr,
    output logic            vram_we,
    input  logic [7:0]      vram_q,
    output logic            io_cs,
    input  logic [7:0]      io_q,
    input  logic            dma_req,
    input  logic            dma_we,
    input  logic [PA_W-1:0] dma_addr,
    input  logic [7:0]      dma_din,
    output logic [7:0]      dma_dout,
    output logic            dma_ack,
    output logic [7:0]      ctrl_q,
    output logic [7:0]      bank_q
);

    typedef enum logic [1:0] {RgnRam, RgnVram, RgnRom, RgnIo} rgn_e;

    rgn_e                rgn, rgn_q, rgn_d;
    logic [7:0]          ctrl_d, bank_d, cpu_dout_q, cpu_dout_d;
    logic                rd_pend_q, rd_pend_d;
    logic [EXP_BITS-1:0] win_sel;
    logic [PA_W-1:0]     cpu_ram_addr;
    logic                wp_hit, reg_hit, cpu_wr, cpu_ram_we, dma_launch;

    always_comb begin
        rgn          = RgnRam;
        wp_hit       = 1'b0;
        win_sel      = cpu_addr[14] ? bank_q[4 +: EXP_BITS] : bank_q[0 +: EXP_BITS];
        cpu_ram_addr = {1'b0, {EXP_BITS{1'b0}}, cpu_addr[14:0]};
        if (cpu_addr[15]) begin
            if (ctrl_q[7]) begin
                cpu_ram_addr = {1'b1, win_sel, cpu_addr[14:0]};
                wp_hit       = cpu_addr[14] ? ctrl_q[1] : ctrl_q[0];
                // Peek-through windows punch the screen and I/O back into the banked space
                if (cpu_addr[14:12] == 3'b000 && ctrl_q[5]) begin
                    rgn = RgnVram;
                end else if (cpu_addr[14:11] == 4'b1101 && ctrl_q[6]) begin
                    rgn = RgnIo;
                end
            end else if (cpu_addr[14:12] == 3'b000) begin
                rgn = RgnVram;
            end else if (cpu_addr[14:11] == 4'b1101) begin
                rgn = RgnIo;
            end else begin
                rgn = RgnRom;
            end
        end
    end

    assign reg_hit    = (cpu_addr[15:1] == 15'h7FF8);
    assign cpu_wr     = ce_cpu & cpu_we;
    assign cpu_ram_we = cpu_wr && (rgn == RgnRam) && !reg_hit && !wp_hit;
    assign vram_we    = cpu_wr && (rgn == RgnVram) && !reg_hit;
    assign io_cs      = (rgn == RgnIo);
    assign rom_addr   = cpu_addr[14:0];
    assign vram_addr  = cpu_addr[9:0];
    assign cpu_dout   = cpu_dout_q;

    always_comb begin
        ctrl_d     = ctrl_q;
        bank_d     = bank_q;
        rd_pend_d  = ce_cpu & ~cpu_we;
        rgn_d      = ce_cpu ? rgn : rgn_q;
        cpu_dout_d = cpu_dout_q;
        if (cpu_wr && reg_hit) begin
            if (cpu_addr[0]) begin
                bank_d = cpu_din;
            end else begin
                ctrl_d = cpu_din;
            end
        end
        if (rd_pend_q) begin
            case (rgn_q)
                RgnRam:  cpu_dout_d = ram_q;
                RgnVram: cpu_dout_d = vram_q;
                RgnRom:  cpu_dout_d = rom_q;
                RgnIo:   cpu_dout_d = io_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= 8'h00;
            bank_q     <= 8'h00;
            rgn_q      <= RgnRam;
            rd_pend_q  <= 1'b0;
            cpu_dout_q <= 8'hFF;
        end else begin
            ctrl_q     <= ctrl_d;
            bank_q     <= bank_d;
            rgn_q      <= rgn_d;
            rd_pend_q  <= rd_pend_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

`ifdef PET_MEMCTL_DMA_EN
    typedef enum logic [1:0] {DmaIdle, DmaWait, DmaAck} dma_st_e;

    dma_st_e    dma_st_q, dma_st_d;
    logic [7:0] dma_dout_q, dma_dout_d;

    always_comb begin
        dma_st_d   = dma_st_q;
        dma_dout_d = dma_dout_q;
        dma_launch = 1'b0;
        unique case (dma_st_q)
            DmaIdle: begin
                // CPU owns the RAM port on ce_cpu cycles; DMA only steals idle slots
                if (dma_req && !ce_cpu) begin
                    dma_launch = 1'b1;
                    dma_st_d   = DmaWait;
                end
            end
            DmaWait: begin
                dma_dout_d = ram_q;
                dma_st_d   = DmaAck;
            end
            DmaAck:  dma_st_d = DmaIdle;
            default: dma_st_d = DmaIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dma_st_q   <= DmaIdle;
            dma_dout_q <= 8'h00;
        end else begin
            dma_st_q   <= dma_st_d;
            dma_dout_q <= dma_dout_d;
        end
    end

    assign dma_ack  = (dma_st_q == DmaAck);
    assign dma_dout = dma_dout_q;
`else
    logic unused_dma;

    assign dma_launch = 1'b0;
    assign dma_ack    = 1'b0;
    assign dma_dout   = 8'h00;
    assign unused_dma = ^{dma_req, dma_we, dma_addr, dma_din};
`endif

    always_comb begin
        ram_addr  = cpu_ram_addr;
        ram_wdata = cpu_din;
        ram_we    = cpu_ram_we;
        if (dma_launch) begin
            ram_addr  = dma_addr;
            ram_wdata = dma_din;
            ram_we    = dma_we;
        end
    end

endmodule

// File: doc/pet_memctl.md
# pet_memctl

Parametrised memory controller for the PET hardware top level: decodes the 6502 bus into base RAM, video RAM, ROM and I/O, and adds 8096-style banked expansion RAM over $8000-$FFFF. Banking is controlled by two write-only registers at $FFF0/$FFF1. A cycle-stealing DMA port reaches the whole physical RAM for PRG injection. Sits between the CPU core and the synchronous block RAMs.

## Interface
Parameters:
- EXP_BITS, 1, bank-select bits per window (2^EXP_BITS banks each for $8000 and $C000 windows; legal 1..4)
- PA_W, 16+EXP_BITS, physical RAM address width (derived; do not override)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ce_cpu  in  1  one-clk strobe marking a CPU bus cycle
- cpu_addr  in  16  CPU address
- cpu_din  in  8  CPU write data (also forwarded to RAM/VRAM/IO write data)
- cpu_we  in  1  CPU write
- cpu_dout  out  8  registered CPU read data
- ram_addr  out  PA_W  physical RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_q  in  8  RAM read data (1-clk latency)
- rom_addr  out  15  ROM address (= cpu_addr[14:0])
- rom_q  in  8  ROM read data (1-clk latency)
- vram_addr  out  10  = cpu_addr[9:0]
- vram_we  out  1  VRAM write enable
- vram_q  in  8  VRAM read data (1-clk latency)
- io_cs  out  1  I/O select, level, decoded from cpu_addr
- io_q  in  8  I/O read data
- dma_req  in  1  DMA request (level)
- dma_we  in  1  DMA write
- dma_addr  in  PA_W  DMA physical address
- dma_din  in  8  DMA write data
- dma_dout  out  8  DMA read data
- dma_ack  out  1  one-clk DMA completion pulse
- ctrl_q  out  8  control register ($FFF0)
- bank_q  out  8  bank register ($FFF1)

## Operation
- ctrl bits: [7] EXP enable, [6] I/O peek-through, [5] screen peek-through, [1] WP $C000-$FFFF, [0] WP $8000-$BFFF; [4:2] stored, no effect.
- bank: [3:0] select for $8000 window, [7:4] for $C000 window; only low EXP_BITS of each nibble used.
- EXP=0 map: 0000-7FFF RAM (ram_addr={0,addr[14:0]}); 8000-8FFF VRAM (mirrored); 9000-E7FF ROM; E800-EFFF I/O; F000-FFFF ROM.
- EXP=1: 8000-FFFF → ram_addr={1,sel,addr[14:0]}, sel from window's nibble; except 8000-8FFF → VRAM if ctrl[5], E800-EFFF → I/O if ctrl[6].
- CPU write to $FFF0/$FFF1 on ce_cpu updates register; underlying memory write suppressed. Reads of those addresses return whatever is mapped.
- CPU write to expansion window with its WP bit set: ram_we stays 0.
- ram_we/vram_we assert only on ce_cpu&cpu_we cycles (or DMA launch).
- DMA FSM: IDLE → (dma_req & !ce_cpu) launch: ram port driven with dma_addr/dma_din/dma_we → WAIT → ACK (dma_dout=ram_q, dma_ack=1) → IDLE. CPU has priority: launch never on a ce_cpu cycle. DMA ignores WP and ctrl.
- Requester drops dma_req in ACK cycle; still high in IDLE = new transfer.

## Timing
- Cycle T: ce_cpu, addresses out combinationally; region select registered. T+1: selected q registered; cpu_dout valid from T+2, held until next update.
- DMA launch legal at T+1 (CPU q already returned). Transfer ≥3 clk, req-to-ack 2 clk when uncontended.
- Register write effective for the access after the writing cycle.
- Reset: ctrl_q=0, bank_q=0, cpu_dout=8'hFF, dma_dout=0, dma_ack=0, FSM IDLE. Reset mid-DMA aborts; no ack issued.

## Configuration
- PET_MEMCTL_DMA_EN defined: DMA FSM and port active as above.
- Undefined: ports remain; dma_ack=0, dma_dout=0, dma inputs ignored, ram port CPU-only.

## Test plan
- Reset, read $0010 after writing $A5 → cpu_dout=$A5 at T+2; ctrl_q=bank_q=0.
- EXP=0, write $3C to $8005 → vram_we pulse, ram_we=0; read $C000 → rom_q, rom_addr=$4000.
- Write ctrl=$80, bank=$10 (EXP_BITS=1), write $77 to $C123 → ram_addr={1,1,$4123}; set bank=$00, read $C123 ≠ path, ram_addr={1,0,$4123}.
- ctrl=$81, write to $9000 → ram_we=0; write to $E900 with ctrl=$C0 → io_cs=1, ram_we=0.
- DMA write $5A to {0,$1234} while ce_cpu pulses every 7 clk → ack within 3 clk of free slot; CPU read $1234 returns $5A; no launch on ce_cpu cycle.
- Assert reset_n=0 during WAIT → dma_ack never pulses, all outputs at reset values.
